rcvshift: RTL and testbench
===========================

# rcvshift

Bit-level asynchronous serial receiver (8N1, LSB first) sitting directly between the `rxd` pad and the receive buffer of the serial line interface. It synchronizes the raw line, detects and validates the start bit, samples each bit at mid-period using the programmable `bit_len`, checks the stop bit, and delivers each byte as a one-cycle strobe. The receive buffer consumes `data_out`/`valid`; framing errors are flagged separately and never strobe `valid`.

## Interface
- No parameters.
- `clk`  in  1  system clock (50 MHz nominal).
- `rst`  in  1  reset, synchronous, active-high.
- `bit_len`  in  16  clocks per bit; sampled only at start-bit detection.
- `serial_in`  in  1  raw asynchronous line, idle high.
- `data_out`  out  8  last received byte; holds until next stop-bit sample.
- `valid`  out  1  one-cycle pulse: byte with good stop bit on `data_out`.
- `frm_err`  out  1  one-cycle pulse: stop bit sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: two flops on `serial_in`, both reset to 1; the output `rxd_s` is the only line view used.
- Latched period: `L` = `bit_len`, captured on the IDLE->START transition. Later `bit_len` changes affect the next frame only.
- Bit-period counter: 16 bits, loads a value, decrements each cycle, and acts when it reads 0.
- States and transitions:
  - IDLE: on `rxd_s`==0, latch `L`, load counter with (`L`>>1)-1, go to START.
  - START: at counter 0, re-sample `rxd_s`.
    - If 0: load `L`-1, clear bit index, go to DATA.
    - If 1 (glitch): return to IDLE with no output.
  - DATA: at counter 0, shift `rxd_s` into bit 7 of the shift register (shift right, LSB first) and reload `L`-1. After bit index 7, go to STOP; otherwise increment the index.
  - STOP: at counter 0, `data_out` <= shift register.
    - If `rxd_s`==1: pulse `valid`, go to IDLE.
    - Else: pulse `frm_err`, go to BREAK.
  - BREAK: wait for `rxd_s`==1, then go to IDLE. This prevents retriggering on a held-low line.
- `valid` and `frm_err` are mutually exclusive. Neither asserts outside the cycle after the stop sample.
- `bit_len` >= 8 is guaranteed by the programming interface (minimum used is 434); smaller values are out of scope.

## Timing
- Reset values: `data_out`=0x00, `valid`=0, `frm_err`=0, `busy`=0, state IDLE, counter 0, index 0, shift register 0x00.
- `rst` mid-frame aborts immediately to the reset values. No pulse is emitted. A line still low after reset is treated as a new start bit two cycles later (synchronizer refill).
- Let T0 be the first clk edge at which `serial_in` is 0. Then:
  - IDLE->START at edge E = T0+2.
  - Start check at E+(`L`>>1).
  - Data bit k (k=0..7) sampled at E+(`L`>>1)+(k+1)·`L`.
  - Stop sampled at E+(`L`>>1)+9·`L`; `valid`/`frm_err` is high for the single following cycle.
- `busy` rises the cycle after E and falls the cycle after the stop sample (good stop) or after BREAK exit.
- Back-to-back frames: a start bit beginning immediately after the stop bit is detected normally. IDLE is entered at mid-stop, ahead of the next falling edge.
- `data_out` changes only at the stop sample edge and is stable while `valid` is high.

## Test plan
- `bit_len`=16, send 0x55 8N1 -> `data_out`=0x55, `valid` high exactly 1 cycle at T0+154, `frm_err` stays 0, `busy` low next cycle.
- `bit_len`=16, `serial_in` low for 4 cycles then high -> START aborts at E+8, with no `valid`/`frm_err` and `busy` low again by T0+11.
- `bit_len`=16, send 0xA3 with stop bit 0 held low 40 cycles -> `frm_err` pulse at T0+154, `data_out`=0xA3, `valid` 0, `busy` high until 3 cycles after line returns high.
- `bit_len`=20, send 0xA3 then 0x00 back-to-back with no idle gap -> two `valid` pulses, `data_out` 0xA3 then 0x00, spaced exactly 200 cycles apart.
- `bit_len`=16 latched; change `bit_len` to 32 during bit 3 of 0x3C -> byte 0x3C received at 16-cycle timing; next frame uses 32.
- Assert `rst` for 1 cycle during bit 5 of a frame with line high -> all outputs return to reset values, no pulse, next 0x7E frame received correctly.

Source files
------------

// File: rtl/rcvshift.sv
// rcvshift: 8N1 LSB-first serial receiver; ports clk, rst, bit_len, serial_in in; data_out, valid, frm_err, busy out
module rcvshift (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bit_len,
  input  logic        serial_in,
  output logic [7:0]  data_out,
  output logic        valid,
  output logic        frm_err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state, state_n;
  logic [1:0]  sync;
  logic        rxd_s;
  logic [15:0] len, len_n, cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  sh, sh_n, data_n;
  logic        valid_n, frm_n, zero;
  assign rxd_s = sync[1];
  assign zero  = cnt == 16'd0;
  assign busy  = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      state    <= IDLE;
      len      <= '0;
      cnt      <= '0;
      idx      <= '0;
      sh       <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      sync     <= {sync[0], serial_in};
      state    <= state_n;
      len      <= len_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      sh       <= sh_n;
      data_out <= data_n;
      valid    <= valid_n;
      frm_err  <= frm_n;
    end
  end
  always_comb begin
    state_n = state;
    len_n   = len;
    cnt_n   = zero ? cnt : cnt - 16'd1;
    idx_n   = idx;
    sh_n    = sh;
    data_n  = data_out;
    valid_n = 1'b0;
    frm_n   = 1'b0;
    case (state)
      IDLE: if (!rxd_s) begin
        len_n   = bit_len;
        cnt_n   = (bit_len >> 1) - 16'd1;
        state_n = START;
      end
      START: if (zero) begin
        cnt_n   = len - 16'd1;
        idx_n   = '0;
        state_n = rxd_s ? IDLE : DATA;
      end
      DATA: if (zero) begin
        sh_n    = {rxd_s, sh[7:1]};
        cnt_n   = len - 16'd1;
        idx_n   = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (zero) begin
        data_n  = sh;
        valid_n = rxd_s;
        frm_n   = !rxd_s;
        state_n = rxd_s ? IDLE : BRK;
      end
      BRK: state_n = rxd_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rcvshift.sv
// tb_rcvshift: vector table, corner sequences and random frames against a timing-formula model
module tb_rcvshift;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bit_len = 16'd16;
  logic        serial_in = 1'b1;
  logic [7:0]  data_out;
  logic        valid, frm_err, busy;
  int          cyc = 0;
  int          n_pass = 0, n_total = 0;

  typedef struct {int c; logic v; logic f; logic [7:0] d; logic b;} ev_t;
  typedef struct {int len; logic [7:0] data; logic good; int off; logic exp_v; logic exp_f;} vec_t;
  ev_t  evq[$];
  vec_t vecs[6];

  rcvshift dut (
    .clk(clk), .rst(rst), .bit_len(bit_len), .serial_in(serial_in),
    .data_out(data_out), .valid(valid), .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid || frm_err) evq.push_back('{cyc, valid, frm_err, data_out, busy});

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic send_frame(input int len, input logic [7:0] b, input logic stop_lvl,
                            input int stop_len, output int t0);
    serial_in = 1'b0;
    t0 = cyc + 1;
    repeat (len) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      serial_in = b[k];
      repeat (len) @(negedge clk);
    end
    serial_in = stop_lvl;
    repeat (stop_len) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic check_one(input string name, input int t0, input int len, input logic [7:0] b,
                           input logic good);
    ev_t e;
    check({name, "_count"}, evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({name, "_time"}, e.c - t0, 2 + len / 2 + 9 * len);
      check({name, "_valid"}, e.v, good);
      check({name, "_frm"}, e.f, !good);
      check({name, "_data"}, e.d, b);
      check({name, "_busy"}, e.b, !good);
    end
    evq.delete();
  endtask

  initial begin
    int t0, t1, len, gap;
    logic [7:0] b;
    logic good;
    ev_t e;
    vecs[0] = '{16, 8'h55, 1'b1, 154, 1'b1, 1'b0};
    vecs[1] = '{20, 8'hA3, 1'b1, 192, 1'b1, 1'b0};
    vecs[2] = '{17, 8'h01, 1'b1, 163, 1'b1, 1'b0};
    vecs[3] = '{24, 8'hFF, 1'b1, 230, 1'b1, 1'b0};
    vecs[4] = '{16, 8'hA3, 1'b0, 154, 1'b0, 1'b1};
    vecs[5] = '{434, 8'h96, 1'b1, 4125, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", data_out, 0);
    check("rst_valid", valid, 0);
    check("rst_frm", frm_err, 0);
    check("rst_busy", busy, 0);

    foreach (vecs[i]) begin
      ev_t v;
      bit_len = vecs[i].len[15:0];
      send_frame(vecs[i].len, vecs[i].data, vecs[i].good,
                 vecs[i].good ? vecs[i].len : vecs[i].len + 24, t0);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_count", i), evq.size(), 1);
      if (evq.size() > 0) begin
        v = evq.pop_front();
        check($sformatf("vec%0d_time", i), v.c - t0, vecs[i].off);
        check($sformatf("vec%0d_valid", i), v.v, vecs[i].exp_v);
        check($sformatf("vec%0d_frm", i), v.f, vecs[i].exp_f);
        check($sformatf("vec%0d_data", i), v.d, vecs[i].data);
      end
      check($sformatf("vec%0d_hold", i), data_out, vecs[i].data);
      evq.delete();
    end

    bit_len = 16;
    serial_in = 1'b0;
    t0 = cyc + 1;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_busy_before", busy, 1);
    @(negedge clk);
    check("glitch_busy_after", busy, 0);
    check("glitch_at_t0_10", cyc - t0, 10);
    repeat (20) @(negedge clk);
    check("glitch_no_pulse", evq.size(), 0);
    evq.delete();

    send_frame(16, 8'hA3, 1'b0, 40, t0);
    t1 = t0 + 184;
    @(negedge clk);
    @(negedge clk);
    check("break_busy_tr1", busy, 1);
    @(negedge clk);
    check("break_busy_tr2", busy, 0);
    check("break_tr_cycle", cyc, t1 + 2);
    check_one("break", t0, 16, 8'hA3, 1'b0);

    bit_len = 20;
    send_frame(20, 8'hA3, 1'b1, 20, t0);
    send_frame(20, 8'h00, 1'b1, 20, t1);
    repeat (4) @(negedge clk);
    check("b2b_count", evq.size(), 2);
    if (evq.size() == 2) begin
      e = evq.pop_front();
      check("b2b_t1", e.c - t0, 192);
      check("b2b_d1", e.d, 8'hA3);
      len = e.c;
      e = evq.pop_front();
      check("b2b_space", e.c - len, 200);
      check("b2b_d2", e.d, 8'h00);
      check("b2b_v2", e.v, 1);
    end
    evq.delete();

    bit_len = 16;
    fork
      send_frame(16, 8'h3C, 1'b1, 16, t0);
      begin
        repeat (69) @(negedge clk);
        bit_len = 32;
      end
    join
    repeat (4) @(negedge clk);
    check_one("blchg_a", t0, 16, 8'h3C, 1'b1);
    send_frame(32, 8'h81, 1'b1, 32, t0);
    repeat (4) @(negedge clk);
    check_one("blchg_b", t0, 32, 8'h81, 1'b1);

    bit_len = 16;
    fork
      send_frame(16, 8'hE0, 1'b1, 16, t0);
      begin
        repeat (104) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_frm", frm_err, 0);
      end
    join
    repeat (20) @(negedge clk);
    check("midrst_no_pulse", evq.size(), 0);
    evq.delete();
    send_frame(16, 8'h7E, 1'b1, 16, t0);
    repeat (4) @(negedge clk);
    check_one("midrst_next", t0, 16, 8'h7E, 1'b1);

    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(8, 40);
      b = 8'($urandom);
      good = $urandom_range(0, 4) != 0;
      gap = $urandom_range(2, 6);
      bit_len = len[15:0];
      send_frame(len, b, good, good ? len : len + $urandom_range(1, 10), t0);
      repeat (gap) @(negedge clk);
      check_one($sformatf("rnd%0d", r), t0, len, b, good);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
